// File: rtl/cfglut5_loader.sv
// Purpose : serially (re)loads a CFGLUT5 truth table MSB first and reads back the table it displaces.
// Latency : handshake at edge N -> cfg_ce high cycles N+1..N+32, done pulse cycle N+33, req_rdy again N+34.
// Backpr. : req_rdy is high only while idle; requests presented during a load are not accepted or queued.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   req_vld/req_rdy     reconfiguration request handshake; req_init sampled only on handshake
//   cfg_ce, cfg_cdi     shift enable and serial data (MSB first) towards the LUT
//   cfg_cdo             serial data out of the LUT (its current bit 31)
//   lut_valid           LUT holds a complete, known truth table
//   done                one-cycle pulse when a load completes
//   old_init            truth table displaced by the last completed load
module cfglut5_loader #(
    parameter logic [31:0] INIT      = 32'h00000000,
    parameter logic        BOOT_LOAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [31:0] req_init,
    output logic        cfg_ce,
    output logic        cfg_cdi,
    input  logic        cfg_cdo,
    output logic        lut_valid,
    output logic        done,
    output logic [31:0] old_init
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam state_t RST_STATE = BOOT_LOAD ? ST_BOOT : ST_IDLE;

    state_t      state;
    logic [31:0] shreg;
    logic [31:0] cap;
    logic [4:0]  cnt;

    // cfg_ce is a flop that is high exactly while in SHIFT, so gating the
    // shift register MSB with it keeps cfg_cdi at 0 outside SHIFT and in reset.
    assign cfg_cdi = cfg_ce & shreg[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            shreg     <= '0;
            cap       <= '0;
            cnt       <= '0;
            cfg_ce    <= 1'b0;
            req_rdy   <= 1'b0;
            done      <= 1'b0;
            lut_valid <= 1'b0;
            old_init  <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    shreg     <= INIT;
                    cnt       <= '0;
                    cfg_ce    <= 1'b1;
                    lut_valid <= 1'b0;
                    state     <= ST_SHIFT;
                end
                ST_IDLE: begin
                    // Ready rises on the first idle edge after reset, so no
                    // handshake can coincide with reset release.
                    req_rdy <= 1'b1;
                    if (req_vld && req_rdy) begin
                        shreg     <= req_init;
                        cnt       <= '0;
                        cfg_ce    <= 1'b1;
                        lut_valid <= 1'b0;
                        req_rdy   <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg <= {shreg[30:0], 1'b0};
                    cap   <= {cap[30:0], cfg_cdo};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        // cap only has 31 new bits at this edge; include the
                        // bit being sampled now to get the full previous table.
                        old_init  <= {cap[30:0], cfg_cdo};
                        cfg_ce    <= 1'b0;
                        done      <= 1'b1;
                        lut_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    req_rdy <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= RST_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfglut5_loader.sv
// Purpose : self-checking bench for cfglut5_loader against a CFGLUT5 shift model and a word-level reference.
// Latency : each load is observed over the 34 cycles following its start edge.
// Backpr. : request inputs are randomised while the loader is busy to show they are ignored.
module tb_cfglut5_loader;

    localparam logic [31:0] INIT_W = 32'hDEADBEEF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // boot-loading instance
    logic        rst_n, req_vld, req_rdy, cfg_ce, cfg_cdi, cfg_cdo, lut_valid, done;
    logic [31:0] req_init, old_init;
    // no-boot instance
    logic        rst2_n, req_vld2, req_rdy2, cfg_ce2, cfg_cdi2, cfg_cdo2, lut_valid2, done2;
    logic [31:0] req_init2, old_init2;

    cfglut5_loader #(.INIT(INIT_W), .BOOT_LOAD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_init(req_init), .cfg_ce(cfg_ce), .cfg_cdi(cfg_cdi), .cfg_cdo(cfg_cdo),
        .lut_valid(lut_valid), .done(done), .old_init(old_init)
    );

    cfglut5_loader #(.INIT(INIT_W), .BOOT_LOAD(1'b0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req_vld(req_vld2), .req_rdy(req_rdy2),
        .req_init(req_init2), .cfg_ce(cfg_ce2), .cfg_cdi(cfg_cdi2), .cfg_cdo(cfg_cdo2),
        .lut_valid(lut_valid2), .done(done2), .old_init(old_init2)
    );

    // CFGLUT5 models: 32-bit shift register, shifts in CDI when CE, CDO = bit 31,
    // O6 = table[{I4..I0}].
    logic [31:0] lut, lut2, lut_preset;
    logic        preset_en;
    assign cfg_cdo  = lut[31];
    assign cfg_cdo2 = lut2[31];
    always @(posedge clk) begin
        if (preset_en) lut <= lut_preset;
        else if (cfg_ce) lut <= {lut[30:0], cfg_cdi};
    end
    always @(posedge clk) begin
        if (preset_en) lut2 <= 32'h0;
        else if (cfg_ce2) lut2 <= {lut2[30:0], cfg_cdi2};
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] lut_exp;   // word the LUT is expected to hold

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for req_rdy with the word presented, then pass the handshake edge.
    task automatic request(input logic [31:0] word);
        int n = 0;
        req_vld  = 1'b1;
        req_init = word;
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hs_wait", 32'(n < 100), 32'd1);
        @(posedge clk);
    endtask

    // Observe cycles 1..34 after a load's start edge. abort_k != 0 asserts reset
    // in that cycle and returns.
    task automatic observe(input logic [31:0] word, input logic [31:0] exp_old,
                           input bit hold_vld, input int abort_k);
        logic [31:0] got = 32'h0;
        int ce_n = 0, done_n = 0, done_at = 0, rdy_bad = 0, cdi_bad = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                check("abort_no_done", done_n, 0);
                rst_n = 1'b0;
                #1;
                check("abort_outs", {cfg_ce, req_rdy, lut_valid, done, cfg_cdi}, 32'h0);
                check("abort_old_init", old_init, 32'h0);
                return;
            end
            if (cfg_ce) begin
                ce_n++;
                got = {got[30:0], cfg_cdi};
            end else if (cfg_cdi) begin
                cdi_bad++;
            end
            if (done) begin
                done_n++;
                done_at = k;
            end
            if (k <= 33 && req_rdy) rdy_bad++;
            if (k == 1) check("lv_drop", lut_valid, 0);
            if (k == 33) begin
                check("lv_set", lut_valid, 1);
                check("old_init", old_init, exp_old);
            end
            if (k == 34) check("rdy_back", req_rdy, 1);
            // garbage on the request port while busy
            req_init = $urandom;
            req_vld  = hold_vld ? 1'b1 : 1'($urandom_range(0, 1));
            if (k == 34) req_vld = hold_vld;
        end
        check("ce_cycles", ce_n, 32);
        check("cdi_stream", got, word);
        check("done_count", done_n, 1);
        check("done_cycle", done_at, 33);
        check("rdy_busy", rdy_bad, 0);
        check("cdi_idle", cdi_bad, 0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] words[3];
        int mism, n, lv_early;

        rst_n      = 1'b0;
        rst2_n     = 1'b0;
        req_vld    = 1'b0;
        req_init   = 32'h0;
        req_vld2   = 1'b0;
        req_init2  = 32'h0;
        preset_en  = 1'b1;
        lut_preset = $urandom;
        lut_exp    = lut_preset;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_outs", {cfg_ce, cfg_cdi, req_rdy, done, lut_valid}, 32'h0);
        check("rst_old_init", old_init, 32'h0);
        check("rst2_outs", {cfg_ce2, cfg_cdi2, req_rdy2, done2, lut_valid2}, 32'h0);

        // boot load
        preset_en = 1'b0;
        rst_n     = 1'b1;
        observe(INIT_W, lut_exp, 1'b0, 0);
        lut_exp = INIT_W;

        // readback
        request(32'h12345678);
        observe(32'h12345678, lut_exp, 1'b0, 0);
        lut_exp = 32'h12345678;
        request(32'h0);
        observe(32'h0, lut_exp, 1'b0, 0);
        lut_exp = 32'h0;

        // random requests with random idle gaps
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            w = $urandom;
            request(w);
            observe(w, lut_exp, 1'b0, 0);
            lut_exp = w;
        end

        // back-to-back with req_vld held high
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        request(words[0]);
        for (int i = 0; i < 3; i++) begin
            observe(words[i], lut_exp, 1'b1, 0);
            lut_exp = words[i];
            if (i < 2) begin
                req_init = words[i + 1];
                @(posedge clk);
            end
        end
        req_vld = 1'b0;

        // reset mid-load at counter 16, then full INIT reload
        w = $urandom;
        request(w);
        observe(w, lut_exp, 1'b0, 17);
        req_vld = 1'b0;
        lut_exp = {lut_exp[15:0], w[31:16]};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        observe(INIT_W, lut_exp, 1'b0, 0);
        lut_exp = INIT_W;

        // LUT function after loading a single-minterm table
        request(32'h80000000);
        observe(32'h80000000, lut_exp, 1'b0, 0);
        lut_exp = 32'h80000000;
        mism = 0;
        for (int a = 0; a < 32; a++) begin
            if (lut[a] !== (a == 31)) mism++;
        end
        check("lut_fn_mism", mism, 0);
        check("lut_o6_1f", lut[31], 1);
        check("lut_o6_00", lut[0], 0);

        // no-boot instance
        rst2_n = 1'b1;
        @(negedge clk);
        check("nb_rdy", req_rdy2, 1);
        check("nb_lv", lut_valid2, 0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (cfg_ce2) n++;
        end
        check("nb_ce_idle", n, 0);
        w = $urandom;
        req_vld2  = 1'b1;
        req_init2 = w;
        @(posedge clk);
        @(negedge clk);
        req_vld2 = 1'b0;
        n = 0;
        lv_early = 0;
        while (!done2 && n < 60) begin
            if (lut_valid2) lv_early++;
            @(negedge clk);
            n++;
        end
        check("nb_done_seen", 32'(n < 60), 32'd1);
        check("nb_lv_early", lv_early, 0);
        check("nb_lv_set", lut_valid2, 1);
        check("nb_lut", lut2, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cfglut5_loader.md
CFGLUT5_LOADER -- requirements
Module: cfglut5_loader

Interface
REQ-001 SHALL have parameter INIT, 32 bits, default 32'h00000000: truth table loaded automatically after reset when BOOT_LOAD=1.
REQ-002 SHALL have parameter BOOT_LOAD, 1 bit, default 1'b1: 1 = auto-load INIT after reset, 0 = wait for the first request.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port REQ_VLD, input, 1: reconfiguration request valid.
REQ-006 SHALL have port REQ_RDY, output, 1: controller can accept a request.
REQ-007 SHALL have port REQ_INIT, input, 32: new truth table, sampled only on handshake.
REQ-008 SHALL have port CFG_CE, output, 1: shift enable to the reconfigurable LUT.
REQ-009 SHALL have port CFG_CDI, output, 1: serial config data to the LUT, MSB first.
REQ-010 SHALL have port CFG_CDO, input, 1: serial data out of the LUT (current bit 31).
REQ-011 SHALL have port LUT_VALID, output, 1: LUT holds a complete, known truth table.
REQ-012 SHALL have port DONE, output, 1: one-cycle pulse marking load completion.
REQ-013 SHALL have port OLD_INIT, output, 32: truth table displaced by the last completed load.

Function
REQ-014 SHALL implement the states BOOT, IDLE, SHIFT and DONE.
REQ-015 SHALL assert REQ_RDY only in IDLE; a handshake is REQ_VLD=1 and REQ_RDY=1 on a rising CLK edge.
REQ-016 SHALL capture REQ_INIT into a 32-bit shift register on handshake, then move IDLE->SHIFT.
REQ-017 SHALL ignore REQ_VLD and REQ_INIT in BOOT, SHIFT and DONE; no request is queued.
REQ-018 SHALL, in BOOT, load parameter INIT into the shift register and move to SHIFT on the first edge after reset release.
REQ-019 SHALL, in SHIFT, drive CFG_CE=1 and CFG_CDI=shreg[31] for exactly 32 consecutive cycles.
- Each edge shifts shreg left by one.
- A 5-bit counter runs 0..31; it wraps 31->0 and the FSM moves SHIFT->DONE on the wrap edge.
REQ-020 SHALL drive CFG_CE=0 and CFG_CDI=0 outside SHIFT.
REQ-021 SHALL sample CFG_CDO on every SHIFT edge into a capture register (cap <= {cap[30:0], CFG_CDO}), so that cap equals the previous LUT contents after 32 shifts.
REQ-022 SHALL update OLD_INIT from cap on the SHIFT->DONE edge; OLD_INIT holds its value otherwise.
REQ-023 SHALL hold DONE=1 for exactly the single DONE-state cycle, then move DONE->IDLE.
REQ-024 SHALL drop LUT_VALID to 0 in the first SHIFT cycle, set it to 1 in the DONE cycle, and otherwise hold it.
REQ-025 SHALL meet this timing: handshake at edge N; CFG_CE high in cycles N+1..N+32; DONE in cycle N+33; REQ_RDY=1 again in cycle N+34.
REQ-026 SHALL, with REQ_VLD held high, accept back-to-back requests 34 cycles apart with no gap cycles beyond REQ-025.

Reset
REQ-027 SHALL, while RST_N=0, immediately force these values:
- CFG_CE=0, CFG_CDI=0, REQ_RDY=0, DONE=0, LUT_VALID=0.
- OLD_INIT=0, shreg=0, cap=0, counter=0.
REQ-028 SHALL, after reset, start in BOOT if BOOT_LOAD=1, else in IDLE with LUT_VALID=0 until the first DONE.
REQ-029 SHALL, on reset during SHIFT, abandon the partial load without a DONE pulse; with BOOT_LOAD=1 the next load is a full INIT reload.

Verification
REQ-030 SHALL cover boot: BOOT_LOAD=1, INIT=32'hDEADBEEF -> CFG_CDI over the 32 CE cycles equals DEADBEEF MSB first, DONE in cycle 33 after release, LUT_VALID=1.
REQ-031 SHALL cover readback: LUT model holding DEADBEEF, request 32'h12345678 -> OLD_INIT=32'hDEADBEEF; then request 32'h0 -> OLD_INIT=32'h12345678.
REQ-032 SHALL cover request blocking: REQ_VLD held high with REQ_INIT changing every cycle during SHIFT -> one load per handshake, words sampled only at handshakes, handshakes 34 cycles apart.
REQ-033 SHALL cover reset mid-load: RST_N low at SHIFT counter=16 -> CFG_CE, REQ_RDY and LUT_VALID go to 0 at once, no DONE; after release a full INIT reload completes.
REQ-034 SHALL cover no-boot: BOOT_LOAD=0 -> REQ_RDY=1 in the first cycle after release, CFG_CE stays 0, LUT_VALID=0 until the first DONE.
REQ-035 SHALL cover LUT function: load 32'h80000000 into a CFGLUT5 model -> output 1 only for {I4..I0}=5'h1F, 0 for all other 31 inputs.
